// File: rtl/mul_add_seq_if.sv
// Handshake and operand bundle for the sequential multiply-accumulate unit.
// master: drives en/x/y/z, observes p/done/busy (the requester).
// slave : the mul_add_seq datapath.
interface mul_add_seq_if #(
  parameter int unsigned W = 32
);
  logic           en;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic [W-1:0]   z;
  logic [2*W-1:0] p;
  logic           done;
  logic           busy;

  modport master (
    output en, x, y, z,
    input  p, done, busy
  );

  modport slave (
    input  en, x, y, z,
    output p, done, busy
  );
endinterface

// File: rtl/mul_add_seq.sv
// Sequential unsigned multiply-accumulate: p = x*y + z, one shift-add step
// per clock, fixed latency of W+1 cycles after the accept edge.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of mul_add_seq_if:
//           en (start, sampled in IDLE only), x/y/z operands,
//           p (registered result, held), done (one-cycle pulse), busy.
module mul_add_seq #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_add_seq_if.slave bus
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  p_q, p_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  assign bus.p    = p_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    done_d   = done_q;
    busy_d   = busy_q;

    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (bus.en) begin
          // Addend preloads the accumulator so no final add step is needed.
          acc_d    = PW'(bus.z);
          mcand_d  = PW'(bus.x);
          mplier_d = bus.y;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Always W iterations; no early exit so latency is data-independent.
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        p_d     = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_add_seq.sv
// Self-checking bench for mul_add_seq (W=32): directed vector table,
// busy-time ignore check, continuous-en throughput, divider round-trip
// loop and mid-operation reset.
module tb_mul_add_seq;

  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mul_add_seq_if #(.W(W)) bus ();

  mul_add_seq #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] held_res(input int c);
    return 64'(c + 1) * 64'(c + 2) + 64'(c + 3);
  endfunction

  // Starts one operation at a negedge and returns on the negedge where done is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [63:0] exp, input string tag, input bit noise);
    int lat;
    int bcnt;
    bus.en = 1'b1;
    bus.x  = a;
    bus.y  = b;
    bus.z  = c;
    @(posedge clk);
    lat  = -1;
    bcnt = 0;
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = j;
        break;
      end
      if (bus.busy) bcnt++;
      if (noise) begin
        bus.en = (j % 2 == 0);
        bus.x  = $urandom;
        bus.y  = $urandom;
        bus.z  = $urandom;
      end else begin
        bus.en = 1'b0;
      end
    end
    bus.en = 1'b0;
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done expected=done_within_40", tag);
    end else begin
      chk({tag, "_latency"}, 64'(lat), 64'd33);
      chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
      chk({tag, "_p"}, bus.p, exp);
    end
  endtask

  initial begin
    logic [31:0] a, b, q, r;
    logic [63:0] p_before;
    int spurious;
    checks   = 0;
    failures = 0;

    vecs[0] = '{32'd7,          32'd6,          32'd5,          64'd47};
    vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFF_00000000};
    vecs[2] = '{32'h12345678,   32'd0,          32'd9,          64'd9};
    vecs[3] = '{32'd0,          32'd0,          32'd0,          64'd0};
    vecs[4] = '{32'd14,         32'd7,          32'd2,          64'd100};
    vecs[5] = '{32'hFFFFFFFF,   32'd1,          32'd0,          64'h00000000_FFFFFFFF};
    vecs[6] = '{32'd1,          32'hFFFFFFFF,   32'd1,          64'h00000001_00000000};
    vecs[7] = '{32'h80000000,   32'd2,          32'd0,          64'h00000001_00000000};
    vecs[8] = '{32'h00010000,   32'h00010000,   32'hFFFFFFFF,   64'h00000001_FFFFFFFF};
    vecs[9] = '{32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_FFFFFFFF};

    rst_n  = 1'b0;
    bus.en = 1'b0;
    bus.x  = '0;
    bus.y  = '0;
    bus.z  = '0;
    #12;
    chk("reset_p", bus.p, 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First vector plus pulse-width and hold check.
    run_op(vecs[0].x, vecs[0].y, vecs[0].z, vecs[0].exp, "vec0", 1'b0);
    @(negedge clk);
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("p_holds", bus.p, 64'd47);

    for (int i = 1; i < 10; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].z, vecs[i].exp, $sformatf("vec%0d", i), 1'b0);
    end

    // en toggling and operand churn while busy must not disturb the result.
    run_op(32'd7, 32'd6, 32'd5, 64'd47, "noise", 1'b1);

    // Divider round-trip: q*b + r rebuilds a.
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (b == 0) b = 32'd1;
      q = a / b;
      r = a % b;
      run_op(q, b, r, 64'(a), $sformatf("rt%0d", i), 1'b0);
    end

    // en held high with per-cycle operands: accepts every 34 cycles.
    spurious = 0;
    bus.en = 1'b1;
    for (int c = 0; c <= 102; c++) begin
      if (c > 0) begin
        @(negedge clk);
        if (c % 34 == 0) begin
          chk($sformatf("held_done_c%0d", c), 64'(bus.done), 64'd1);
          chk($sformatf("held_p_c%0d", c), bus.p, held_res(c - 34));
        end else if (bus.done) begin
          spurious++;
        end
      end
      bus.x = 32'(c + 1);
      bus.y = 32'(c + 2);
      bus.z = 32'(c + 3);
    end
    chk("held_spurious_done", 64'(spurious), 64'd0);

    // Operation accepted at the last held edge; reset it 10 cycles into CALC.
    @(negedge clk);
    bus.en = 1'b0;
    repeat (10) @(negedge clk);
    p_before = bus.p;
    chk("pre_reset_p", p_before, held_res(68));
    chk("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_p", bus.p, 64'd0);
    chk("midreset_done", 64'(bus.done), 64'd0);
    chk("midreset_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd3, 32'd4, 32'd0, 64'd12, "post_reset", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
- Sequential unsigned multiply-accumulate: computes p = x*y + z using one shift-add step per clock.
- Sits beside the sequential divider in the math module group and uses the same en/done handshake.
- Rebuilds a dividend from quotient, divisor and remainder (q*b + r). This supports divider self-check and the tracker's scaling and centroid arithmetic.

Parameters:
- W, 32, operand width in bits; result width is 2*W.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  start request; sampled only in IDLE.
- x  input  W  multiplicand, unsigned.
- y  input  W  multiplier, unsigned.
- z  input  W  addend, unsigned, zero-extended to 2*W.
- p  output  2*W  result x*y+z; registered; holds until the next result.
- done  output  1  one-cycle pulse; p is valid on the same cycle.
- busy  output  1  high from the cycle after en is accepted until done is asserted.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - p=0, done=0, busy=0.
  - state=IDLE; internal registers cleared.
- States: IDLE, CALC, DONE (one-hot or binary; implementation's choice).
- IDLE:
  - done<=0.
  - If en=1, latch operands: acc<={W'b0,z}, mcand<={W'b0,x}, mplier<=y, cnt<=0, busy<=1, go to CALC.
  - If en=0, stay in IDLE; p holds its value.
- CALC, one iteration per cycle:
  - If mplier[0], acc<=acc+mcand (2*W-bit add, no overflow possible).
  - mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - After the W-th iteration (cnt==W-1 at the edge), go to DONE.
- DONE: p<=acc, done<=1, busy<=0, go to IDLE.
- Latency:
  - en sampled high at edge k; done=1 and p valid after edge k+W+1, for exactly one cycle.
  - Fixed, independent of operand values; no early termination.
- Throughput: the next en is accepted on the cycle done=1, because the state is IDLE then. Back-to-back period is W+2 cycles.
- en while busy (CALC/DONE): ignored; no queuing; latched operands are unaffected.
- x, y, z may change freely after the accept edge.
- Width rule: the maximum result is (2^W-1)^2+(2^W-1) = 2^(2W)-2^W, so it always fits in 2*W bits; no saturation or carry-out.
- Reset mid-operation: aborts immediately; no done pulse; p returns to 0.
- cnt width: ceil(log2(W))+1 bits.

Test Plan:
- W=32, x=7, y=6, z=5, single en pulse -> done exactly 33 edges after the accept edge; p=0x2F (47); busy high for 33 cycles.
- x=0xFFFFFFFF, y=0xFFFFFFFF, z=0xFFFFFFFF -> p=0xFFFFFFFF_00000000; no wrap.
- x=0x12345678, y=0, z=9 -> p=9. Then x=0, y=0, z=0 -> p=0; done still pulses with full latency.
- Divider round-trip: a=100, b=7 gives q=14, r=2; feed x=14, y=7, z=2 -> p=100. Run a randomized loop of 1000 pairs with check p==a.
- en held high continuously with changing operands:
  - Only operands at the accept edges are used.
  - Results arrive every 34 cycles.
  - en pulses during CALC are ignored.
  - The accept coincides with the done cycle.
- rst_n asserted 10 cycles into CALC -> p=0, done=0, busy=0 immediately. After release, a fresh en with x=3, y=4, z=0 -> p=12.
